// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and two-digit code register.
// Columns are driven active-low one at a time; rows are read back through a
// 2-flop synchronizer and evaluated once per SCAN_DIV-cycle sample tick.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat strobes while a key is held).
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_SCANS = 100
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] value
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t        state;
    logic [1:0]    row_sync;
    logic [3:0]    row_meta;
    logic [3:0]    rs;
    logic [3:0]    lat;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          tick;
    logic [3:0]    scan_code;
    logic [3:0]    lat_code;

    // Index of the single low bit of an active-low one-hot pattern.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Keypad legend, indexed by {row, column}.
    function automatic logic [3:0] hex_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
            4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
            4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
            4'hC: return 4'h0;  4'hD: return 4'hF;  4'hE: return 4'hE;  default: return 4'hD;
        endcase
    endfunction

    assign row_sync  = '0;
    assign tick      = (div == DIV_LAST);
    assign cnt_next  = cnt + 1'b1;
    assign scan_code = hex_code(low_index(rs), low_index(col));
    assign lat_code  = hex_code(low_index(lat), low_index(col));

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS);
    logic [RW-1:0] rep;
`else
    // REPEAT_SCANS only has meaning when auto-repeat is built in.
    logic unused_repeat;
    assign unused_repeat = (REPEAT_SCANS > 0) | (|row_sync);
`endif

    // Two-flop synchronizer for the asynchronous row inputs (idle high).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            row_meta <= 4'b1111;
            rs       <= 4'b1111;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // Free-running sample divider; restarts only on clr.
    always_ff @(posedge clk) begin
        if (clr) div <= '0;
        else     div <= tick ? '0 : div + 1'b1;
    end

    // Scan / debounce / hold state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_SCAN;
            col       <= 4'b1110;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            value     <= 8'h00;
            lat       <= 4'b1111;
            cnt       <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    S_SCAN: begin
                        if (one_low(rs)) begin
                            lat <= rs;
                            if (DEBOUNCE == 1) begin
                                state     <= S_PRESSED;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                                key       <= scan_code;
                                value     <= {value[3:0], scan_code};
`ifdef KEYPAD_REPEAT_EN
                                rep       <= '0;
`endif
                            end else begin
                                cnt   <= CW'(1);
                                state <= S_DEBOUNCE;
                            end
                        end else begin
                            col <= {col[2:0], col[3]};
                        end
                    end
                    S_DEBOUNCE: begin
                        if (rs == lat) begin
                            if (cnt_next == DB_LAST) begin
                                state     <= S_PRESSED;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                                key       <= lat_code;
                                value     <= {value[3:0], lat_code};
`ifdef KEYPAD_REPEAT_EN
                                rep       <= '0;
`endif
                            end else begin
                                cnt <= cnt_next;
                            end
                        end else begin
                            state <= S_SCAN;
                            col   <= {col[2:0], col[3]};
                        end
                    end
                    S_PRESSED: begin
                        if (rs == 4'b1111) begin
                            if (DEBOUNCE == 1) begin
                                state    <= S_SCAN;
                                key_held <= 1'b0;
                                col      <= {col[2:0], col[3]};
                            end else begin
                                cnt   <= CW'(1);
                                state <= S_RELEASE;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rs == lat) begin
                            if (rep + 1'b1 == REP_LAST) begin
                                rep       <= '0;
                                key_valid <= 1'b1;
                                key       <= lat_code;
                                value     <= {value[3:0], lat_code};
                            end else begin
                                rep <= rep + 1'b1;
                            end
                        end
`endif
                    end
                    S_RELEASE: begin
                        if (rs == 4'b1111) begin
                            if (cnt_next == DB_LAST) begin
                                state    <= S_SCAN;
                                key_held <= 1'b0;
                                col      <= {col[2:0], col[3]};
                            end else begin
                                cnt <= cnt_next;
                            end
                        end else begin
                            // Release bounce: back to held, no new strobe.
                            state <= S_PRESSED;
                        end
                    end
                    default: state <= S_SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE=3, REPEAT_SCANS=5.
// A small keypad model pulls a row low when its key is pressed and its column is driven.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;
    logic [7:0]  value;

    logic [15:0] pressed;        // bit r*4+c = key at row r, column c held down
    logic        watch;
    int          cyc;
    int          strobe_cnt = 0;
    int          dbl_cnt    = 0;
    int          drop_cnt   = 0;
    int          n_tests    = 0;
    int          n_fail     = 0;
    logic        prev_valid = 1'b0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_SCANS(5)) dut (
        .clk       (clk),
        .clr       (clr),
        .row       (row),
        .col       (col),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Cycles since reset; mirrors the known tick schedule (tick on cyc % 4 == 0).
    always @(posedge clk) begin
        if (clr) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Strobe, back-to-back strobe and held-drop counters.
    always @(negedge clk) begin
        if (key_valid) strobe_cnt = strobe_cnt + 1;
        if (key_valid && prev_valid) dbl_cnt = dbl_cnt + 1;
        prev_valid = key_valid;
        if (watch && !key_held) drop_cnt = drop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input string tag, input int max);
        logic found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (key_valid) found = 1'b1;
        end
        #1;
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_release(input string tag, input int max);
        logic gone = 1'b0;
        for (int i = 0; i < max && !gone; i++) begin
            @(negedge clk);
            if (!key_held) gone = 1'b1;
        end
        #1;
        check(tag, {31'd0, gone}, 32'd1);
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic next_tick();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % 4 != 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        int s0;
        logic [3:0] seen;
        clr     = 1'b1;
        pressed = '0;
        watch   = 1'b0;

        // Reset state and idle column rotation.
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        check("rst_col", col, 4'b1110);
        check("rst_value", value, 8'h00);
        check("rst_key", key, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        wait_cyc(3);  check("col_c3", col, 4'b1110);
        wait_cyc(4);  check("col_c4", col, 4'b1101);
        wait_cyc(8);  check("col_c8", col, 4'b1011);
        wait_cyc(12); check("col_c12", col, 4'b0111);
        wait_cyc(16); check("col_c16", col, 4'b1110);

        // Clean press of 5, held 40 cycles, then 9.
        s0 = strobe_cnt;
        pressed = 16'h0020;
        wait_strobe("press5_latency", 30);
        check("press5_key", key, 4'h5);
        check("press5_value", value, 8'h05);
        repeat (25) @(negedge clk);
        #1;
        check("press5_held", key_held, 1'b1);
        check("press5_once", strobe_cnt - s0, 1);
        pressed = '0;
        wait_release("press5_release", 30);
        check("press5_after_rel", strobe_cnt - s0, 1);
        pressed = 16'h0400;
        wait_strobe("press9_latency", 30);
        check("press9_key", key, 4'h9);
        check("press9_value", value, 8'h59);
        pressed = '0;
        wait_release("press9_release", 30);

        // Press bounce: never three stable ticks, so no strobe.
        s0 = strobe_cnt;
        next_tick();
        for (int i = 0; i < 8; i++) begin
            pressed = (i % 4 < 2) ? 16'h0020 : 16'h0000;
            next_tick();
        end
        next_tick();
        check("bounce_nostrobe", strobe_cnt - s0, 0);
        pressed = 16'h0020;
        wait_strobe("bounce_stable", 40);
        check("bounce_key", key, 4'h5);
        check("bounce_value", value, 8'h95);

        // Release bounce on the first two release ticks.
        watch = 1'b1;
        pressed = '0;      next_tick();
        pressed = 16'h0020; next_tick();
        pressed = '0;      next_tick();
        pressed = 16'h0020; next_tick();
        next_tick();
        watch = 1'b0;
        #1;
        check("relbounce_held", drop_cnt, 0);
        check("relbounce_once", strobe_cnt - s0, 1);
        pressed = '0;
        wait_release("relbounce_release", 30);
        check("relbounce_total", strobe_cnt - s0, 1);

        // Ghost: keys 1 and 7 share column 0.
        s0 = strobe_cnt;
        seen = 4'b0000;
        pressed = 16'h0101;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | ~col;
        end
        #1;
        check("ghost_nostrobe", strobe_cnt - s0, 0);
        check("ghost_scanning", seen, 4'b1111);
        check("ghost_key", key, 4'h5);
        pressed = 16'h8000;
        wait_strobe("pressD", 30);
        check("pressD_key", key, 4'hD);
        check("pressD_value", value, 8'h5D);
        pressed = '0;
        wait_release("pressD_release", 30);

        // Reset while A is held, then re-accept A.
        pressed = 16'h0008;
        wait_strobe("pressA", 30);
        check("pressA_key", key, 4'hA);
        pulse_clr();
        check("midrst_col", col, 4'b1110);
        check("midrst_key", key, 4'h0);
        check("midrst_value", value, 8'h00);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_held", key_held, 1'b0);
        s0 = strobe_cnt;
        wait_strobe("reaccept", 40);
        check("reaccept_cyc", cyc, 24);
        check("reaccept_key", key, 4'hA);
        check("reaccept_value", value, 8'h0A);
        check("reaccept_once", strobe_cnt - s0, 1);

        // Hold 7 from reset: auto-repeat every 5 ticks if built in.
        pressed = 16'h0100;
        pulse_clr();
        s0 = strobe_cnt;
        wait_strobe("hold7_first", 20);
        check("hold7_cyc", cyc, 12);
        check("hold7_value", value, 8'h07);
`ifdef KEYPAD_REPEAT_EN
        wait_strobe("rep1", 25);
        check("rep1_cyc", cyc, 32);
        check("rep1_value", value, 8'h77);
        wait_strobe("rep2", 25);
        check("rep2_cyc", cyc, 52);
        check("rep2_value", value, 8'h77);
        check("rep_count", strobe_cnt - s0, 3);
`else
        repeat (60) @(negedge clk);
        #1;
        check("norep_count", strobe_cnt - s0, 1);
        check("norep_value", value, 8'h07);
`endif
        pressed = '0;
        wait_release("hold7_release", 40);

        check("no_double_strobe", dbl_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
